// File: rtl/vga_sched_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_sched_if : command, modeline, control and pixel bundle of vga_sched  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface vga_sched_if #(
  parameter int FRM_W = 32
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [15:0]      m_H, m_V;
  logic [7:0]       m_HFP, m_HS, m_HBP, m_VFP, m_VS, m_VBP, m_interlaced;
  logic [15:0]      H, V;
  logic [7:0]       HFP, HS, HBP, VFP, VS, VBP, interlaced;
  logic             vga_reset, vga_frame_reset, vga_soft_reset, vga_wait_vblank, vram_reset;
  logic             vram_active;
  logic             vblank, vram_ready, vram_synced;
  logic             px_valid, px_ready;
  logic [23:0]      px_rgb;
  logic             vram_req;
  logic [7:0]       r_vram_in, g_vram_in, b_vram_in;
  logic             frame_done;
  logic [FRM_W-1:0] frames_done;
  logic [15:0]      sync_err;

  modport slave (
    input  cmd_valid, cmd_op, m_H, m_V, m_HFP, m_HS, m_HBP, m_VFP, m_VS, m_VBP, m_interlaced,
    input  vblank, vram_ready, vram_synced, px_valid, px_rgb,
    output cmd_ready, H, V, HFP, HS, HBP, VFP, VS, VBP, interlaced,
    output vga_reset, vga_frame_reset, vga_soft_reset, vga_wait_vblank, vram_reset, vram_active,
    output px_ready, vram_req, r_vram_in, g_vram_in, b_vram_in, frame_done, frames_done, sync_err
  );

  modport master (
    output cmd_valid, cmd_op, m_H, m_V, m_HFP, m_HS, m_HBP, m_VFP, m_VS, m_VBP, m_interlaced,
    output vblank, vram_ready, vram_synced, px_valid, px_rgb,
    input  cmd_ready, H, V, HFP, HS, HBP, VFP, VS, VBP, interlaced,
    input  vga_reset, vga_frame_reset, vga_soft_reset, vga_wait_vblank, vram_reset, vram_active,
    input  px_ready, vram_req, r_vram_in, g_vram_in, b_vram_in, frame_done, frames_done, sync_err
  );
endinterface
`default_nettype wire

// File: rtl/vga_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_sched : modeline/blit sequencer and pixel forwarder for the vga core |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module vga_sched #(
  parameter int PX_W  = 24,
  parameter int FRM_W = 32
) (
  input  wire logic  clk_sys,
  input  wire logic  reset,
  vga_sched_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_MODE_WAIT  = 3'd1,
    S_MODE_APPLY = 3'd2,
    S_VRAM_CLR   = 3'd3,
    S_STREAM     = 3'd4
  } state_t;

  typedef struct packed {
    logic [15:0] h;
    logic [15:0] v;
    logic [7:0]  hfp, hs, hbp, vfp, vs, vbp, il;
  } modeline_t;

  localparam logic [1:0] C_OP_SET_MODE = 2'd1;
  localparam logic [1:0] C_OP_BLIT     = 2'd2;
  localparam logic [1:0] C_OP_BLANK    = 2'd3;

  state_t           state_q, state_d;
  modeline_t        shadow_q, shadow_d, mode_q, mode_d;
  logic [PX_W-1:0]  frame_size_q, frame_size_d, px_cnt_q, px_cnt_d;
  logic [23:0]      rgb_q, rgb_d;
  logic [FRM_W-1:0] frames_q, frames_d;
  logic [15:0]      sync_err_q, sync_err_d;
  logic             vblank_q, synced_q;
  logic             blank_pend_q, blank_pend_d;
  logic             vram_active_q, vram_active_d;
  logic             vga_reset_q, vga_reset_d, vram_reset_q, vram_reset_d;
  logic             frame_reset_q, frame_reset_d;

  logic             cmd_ready, cmd_acc, vb_edge, sync_fall, px_ready, px_acc, frame_last, enter_clr;
  logic [31:0]      area;
  modeline_t        req_mode;

  assign req_mode = '{h: bus.m_H, v: bus.m_V, hfp: bus.m_HFP, hs: bus.m_HS, hbp: bus.m_HBP,
                      vfp: bus.m_VFP, vs: bus.m_VS, vbp: bus.m_VBP, il: bus.m_interlaced};

  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    mode_d        = mode_q;
    frame_size_d  = frame_size_q;
    px_cnt_d      = px_cnt_q;
    rgb_d         = rgb_q;
    frames_d      = frames_q;
    sync_err_d    = sync_err_q;
    blank_pend_d  = blank_pend_q;
    vram_active_d = vram_active_q;
    vga_reset_d   = 1'b0;
    vram_reset_d  = 1'b0;
    frame_reset_d = 1'b0;
    enter_clr     = 1'b0;
    area          = 32'(shadow_q.h) * 32'(shadow_q.v);

    cmd_ready  = (state_q == S_IDLE) || (state_q == S_STREAM);
    cmd_acc    = bus.cmd_valid && cmd_ready;
    vb_edge    = bus.vblank && !vblank_q;
    sync_fall  = (state_q == S_STREAM) && synced_q && !bus.vram_synced;
    // A SET_MODE on the bus stalls pixels immediately so no beat lands in the old frame size.
    px_ready   = (state_q == S_STREAM) && bus.vram_ready && !blank_pend_q &&
                 (frame_size_q != '0) && !(bus.cmd_valid && (bus.cmd_op == C_OP_SET_MODE));
    px_acc     = bus.px_valid && px_ready;
    frame_last = px_acc && ((px_cnt_q + PX_W'(1)) == frame_size_q);

    if (px_acc) begin
      rgb_d = bus.px_rgb;
      if (frame_last) begin
        px_cnt_d = '0;
        frames_d = frames_q + FRM_W'(1);
      end else begin
        px_cnt_d = px_cnt_q + PX_W'(1);
      end
    end

    if (sync_fall && (sync_err_q != 16'hFFFF)) begin
      sync_err_d = sync_err_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_acc && (bus.cmd_op == C_OP_SET_MODE)) begin
          shadow_d = req_mode;
          state_d  = S_MODE_WAIT;
        end else if (cmd_acc && (bus.cmd_op == C_OP_BLIT)) begin
          enter_clr = 1'b1;
        end
      end
      S_MODE_WAIT: begin
        if (vb_edge) begin
          state_d       = S_MODE_APPLY;
          mode_d        = shadow_q;
          frame_size_d  = PX_W'(area >> (shadow_q.il != 8'd0));
          vga_reset_d   = 1'b1;
          vram_reset_d  = 1'b1;
          vram_active_d = 1'b0;
        end
      end
      S_MODE_APPLY: state_d = S_IDLE;
      S_VRAM_CLR:   state_d = S_STREAM;
      S_STREAM: begin
        if (cmd_acc && (bus.cmd_op == C_OP_SET_MODE)) begin
          shadow_d     = req_mode;
          blank_pend_d = 1'b0;
          state_d      = S_MODE_WAIT;
        end else if (cmd_acc && (bus.cmd_op == C_OP_BLIT)) begin
          blank_pend_d = 1'b0;
          enter_clr    = 1'b1;
        end else if (cmd_acc && (bus.cmd_op == C_OP_BLANK)) begin
          blank_pend_d = 1'b1;
        end else if (blank_pend_q && vb_edge) begin
          blank_pend_d  = 1'b0;
          vram_active_d = 1'b0;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (enter_clr) begin
      state_d       = S_VRAM_CLR;
      px_cnt_d      = '0;
      vram_reset_d  = 1'b1;
      frame_reset_d = 1'b1;
      vram_active_d = 1'b1;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      shadow_q      <= '0;
      mode_q        <= '0;
      frame_size_q  <= '0;
      px_cnt_q      <= '0;
      rgb_q         <= '0;
      frames_q      <= '0;
      sync_err_q    <= '0;
      vblank_q      <= 1'b0;
      synced_q      <= 1'b0;
      blank_pend_q  <= 1'b0;
      vram_active_q <= 1'b0;
      vga_reset_q   <= 1'b0;
      vram_reset_q  <= 1'b0;
      frame_reset_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      mode_q        <= mode_d;
      frame_size_q  <= frame_size_d;
      px_cnt_q      <= px_cnt_d;
      rgb_q         <= rgb_d;
      frames_q      <= frames_d;
      sync_err_q    <= sync_err_d;
      vblank_q      <= bus.vblank;
      synced_q      <= bus.vram_synced;
      blank_pend_q  <= blank_pend_d;
      vram_active_q <= vram_active_d;
      vga_reset_q   <= vga_reset_d;
      vram_reset_q  <= vram_reset_d;
      frame_reset_q <= frame_reset_d;
    end
  end

  assign bus.cmd_ready       = cmd_ready;
  assign bus.H               = mode_q.h;
  assign bus.V               = mode_q.v;
  assign bus.HFP             = mode_q.hfp;
  assign bus.HS              = mode_q.hs;
  assign bus.HBP             = mode_q.hbp;
  assign bus.VFP             = mode_q.vfp;
  assign bus.VS              = mode_q.vs;
  assign bus.VBP             = mode_q.vbp;
  assign bus.interlaced      = mode_q.il;
  assign bus.vga_reset       = vga_reset_q;
  assign bus.vram_reset      = vram_reset_q;
  assign bus.vga_frame_reset = frame_reset_q;
  assign bus.vga_soft_reset  = 1'b0;
  assign bus.vga_wait_vblank = sync_fall;
  assign bus.vram_active     = vram_active_q;
  assign bus.px_ready        = px_ready;
  assign bus.vram_req        = px_acc;
  assign bus.r_vram_in       = rgb_q[23:16];
  assign bus.g_vram_in       = rgb_q[15:8];
  assign bus.b_vram_in       = rgb_q[7:0];
  assign bus.frame_done      = frame_last;
  assign bus.frames_done     = frames_q;
  assign bus.sync_err        = sync_err_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vga_sched : directed bench for vga_sched with a cycle-level model     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_vga_sched;

  typedef struct {
    int h, v, hfp, hs, hbp, vfp, vs, vbp, il;
  } ml_t;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_sys = ~clk_sys;

  vga_sched_if #(.FRM_W(32)) bus ();
  vga_sched #(.PX_W(24), .FRM_W(32)) dut (.clk_sys(clk_sys), .reset(reset), .bus(bus));

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: phase flags, applied/shadow modeline, counters, previous-cycle vblank/synced.
  ml_t         m_app, m_sh;
  logic        m_pend, m_apply, m_clr, m_stream, m_blank, m_active, m_vbp, m_synp;
  int          m_cnt;
  logic [31:0] m_frames;
  int          m_sync;
  logic [23:0] m_rgb;
  logic        e_idle, e_ready, e_pxr, e_req, e_fd, e_wv, e_acc, vb_edge;
  int          fsize;

  always @(negedge clk_sys) begin
    if (reset) begin
      m_app = '{default: 0}; m_sh = '{default: 0};
      m_pend = 0; m_apply = 0; m_clr = 0; m_stream = 0; m_blank = 0; m_active = 0;
      m_vbp = 0; m_synp = 0; m_cnt = 0; m_frames = 0; m_sync = 0; m_rgb = 0;
    end
    fsize   = ((m_app.h * m_app.v) >> ((m_app.il != 0) ? 1 : 0)) & 32'hFFFFFF;
    e_idle  = !m_pend && !m_apply && !m_clr && !m_stream;
    e_ready = e_idle || m_stream;
    e_pxr   = m_stream && bus.vram_ready && !m_blank && (fsize != 0) &&
              !(bus.cmd_valid && bus.cmd_op == 2'd1);
    e_req   = bus.px_valid && e_pxr;
    e_fd    = e_req && (m_cnt + 1 == fsize);
    e_wv    = m_stream && m_synp && !bus.vram_synced;
    e_acc   = bus.cmd_valid && e_ready;
    vb_edge = bus.vblank && !m_vbp;

    chk("cmd_ready", 64'(bus.cmd_ready), 64'(e_ready));
    chk("px_ready", 64'(bus.px_ready), 64'(e_pxr));
    chk("vram_req", 64'(bus.vram_req), 64'(e_req));
    chk("frame_done", 64'(bus.frame_done), 64'(e_fd));
    chk("vga_reset", 64'(bus.vga_reset), 64'(m_apply));
    chk("vram_reset", 64'(bus.vram_reset), 64'(m_apply || m_clr));
    chk("vga_frame_reset", 64'(bus.vga_frame_reset), 64'(m_clr));
    chk("vga_wait_vblank", 64'(bus.vga_wait_vblank), 64'(e_wv));
    chk("vram_active", 64'(bus.vram_active), 64'(m_active));
    chk("modeline_hv", 64'({bus.H, bus.V}), 64'({16'(m_app.h), 16'(m_app.v)}));
    chk("modeline_timing", 64'({bus.HFP, bus.HS, bus.HBP, bus.VFP, bus.VS, bus.VBP, bus.interlaced}),
        64'({8'(m_app.hfp), 8'(m_app.hs), 8'(m_app.hbp), 8'(m_app.vfp), 8'(m_app.vs),
             8'(m_app.vbp), 8'(m_app.il)}));
    chk("vram_rgb", 64'({bus.r_vram_in, bus.g_vram_in, bus.b_vram_in}), 64'(m_rgb));
    chk("frames_done", 64'(bus.frames_done), 64'(m_frames));
    chk("sync_err", 64'(bus.sync_err), 64'(m_sync));

    if (!reset) begin
      if (e_req) begin
        m_rgb = bus.px_rgb;
        if (e_fd) begin m_cnt = 0; m_frames = m_frames + 1; end
        else m_cnt = m_cnt + 1;
      end
      if (e_wv && m_sync < 16'hFFFF) m_sync = m_sync + 1;
      if (m_apply) m_apply = 0;
      else if (m_clr) begin m_clr = 0; m_stream = 1; end
      else if (m_pend) begin
        if (vb_edge) begin m_pend = 0; m_apply = 1; m_app = m_sh; m_active = 0; end
      end else if (e_acc) begin
        if (bus.cmd_op == 2'd1) begin
          m_sh = '{bus.m_H, bus.m_V, bus.m_HFP, bus.m_HS, bus.m_HBP, bus.m_VFP, bus.m_VS,
                   bus.m_VBP, bus.m_interlaced};
          m_pend = 1; m_stream = 0; m_blank = 0;
        end else if (bus.cmd_op == 2'd2) begin
          m_clr = 1; m_stream = 0; m_blank = 0; m_cnt = 0; m_active = 1;
        end else if (bus.cmd_op == 2'd3 && m_stream) m_blank = 1;
      end else if (m_stream && m_blank && vb_edge) begin
        m_stream = 0; m_blank = 0; m_active = 0;
      end
      m_vbp  = bus.vblank;
      m_synp = bus.vram_synced;
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input int h, input int v, input int il);
    bus.cmd_valid = 1'b1; bus.cmd_op = op;
    bus.m_H = 16'(h); bus.m_V = 16'(v);
    bus.m_HFP = 8'(h + 1); bus.m_HS = 8'(h + 2); bus.m_HBP = 8'(v + 3);
    bus.m_VFP = 8'(v + 4); bus.m_VS = 8'(v + 5); bus.m_VBP = 8'(h + 6);
    bus.m_interlaced = 8'(il);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic vblank_pulse();
    bus.vblank = 1'b1; tick(); tick();
    bus.vblank = 1'b0; tick();
  endtask

  task automatic stream(input int n, input logic [23:0] base, output int reqs, output int fds);
    reqs = 0; fds = 0;
    for (int i = 0; i < n; i++) begin
      bus.px_valid = 1'b1; bus.px_rgb = base + 24'(i);
      #1;
      reqs += int'(bus.vram_req); fds += int'(bus.frame_done);
      tick();
    end
    bus.px_valid = 1'b0;
  endtask

  int reqs, fds, cnt;

  initial begin
    bus.cmd_valid = 0; bus.cmd_op = 0; bus.m_H = 0; bus.m_V = 0; bus.m_HFP = 0; bus.m_HS = 0;
    bus.m_HBP = 0; bus.m_VFP = 0; bus.m_VS = 0; bus.m_VBP = 0; bus.m_interlaced = 0;
    bus.vblank = 0; bus.vram_ready = 1; bus.vram_synced = 1; bus.px_valid = 0; bus.px_rgb = 0;
    tick(); tick();
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("rst_H", 64'(bus.H), 64'd0);
    reset = 1'b0; tick();

    // Mode change waits for a vblank rising edge
    send(2'd1, 320, 240, 0);
    chk("t1_ready_in_wait", 64'(bus.cmd_ready), 64'd0);
    repeat (4) tick();
    chk("t1_h_before_vblank", 64'(bus.H), 64'd0);
    bus.vblank = 1'b1; tick();
    chk("t1_hv_applied", 64'({bus.H, bus.V}), 64'({16'd320, 16'd240}));
    chk("t1_vga_reset", 64'(bus.vga_reset), 64'd1);
    chk("t1_vram_reset", 64'(bus.vram_reset), 64'd1);
    tick();
    chk("t1_vga_reset_off", 64'(bus.vga_reset), 64'd0);
    chk("t1_ready_back", 64'(bus.cmd_ready), 64'd1);
    bus.vblank = 1'b0; tick();

    // Stream a 8x6 frame (48 pixels)
    send(2'd1, 8, 6, 0);
    vblank_pulse();
    send(2'd2, 0, 0, 0);
    chk("t2_frame_reset", 64'(bus.vga_frame_reset), 64'd1);
    chk("t2_vram_active", 64'(bus.vram_active), 64'd1);
    tick();
    stream(48, 24'h100000, reqs, fds);
    chk("t2_reqs", 64'(reqs), 64'd48);
    chk("t2_frame_done", 64'(fds), 64'd1);
    chk("t2_frames_done", 64'(bus.frames_done), 64'd1);

    // Backpressure stall mid-frame
    stream(20, 24'hA00000, reqs, fds);
    bus.vram_ready = 1'b0; bus.px_valid = 1'b1; bus.px_rgb = 24'hFFFFFF;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (i == 0) chk("t4_px_ready_stalled", 64'(bus.px_ready), 64'd0);
      cnt += int'(bus.vram_req);
      tick();
    end
    chk("t4_no_req_stall", 64'(cnt), 64'd0);
    chk("t4_rgb_hold", 64'({bus.r_vram_in, bus.g_vram_in, bus.b_vram_in}), 64'(24'hA00013));
    bus.vram_ready = 1'b1;
    stream(28, 24'hB00000, reqs, fds);
    chk("t4_frame_done", 64'(fds), 64'd1);
    chk("t4_frames_done", 64'(bus.frames_done), 64'd2);

    // SET_MODE during STREAM: pixels stall on the command cycle; interlaced 10x8 -> 40
    bus.px_valid = 1'b1; bus.cmd_valid = 1'b1; bus.cmd_op = 2'd1;
    bus.m_H = 16'd10; bus.m_V = 16'd8; bus.m_interlaced = 8'd1;
    #1;
    chk("t3_px_ready_drop", 64'(bus.px_ready), 64'd0);
    tick();
    bus.cmd_valid = 1'b0; bus.px_valid = 1'b0;
    vblank_pulse();
    send(2'd2, 0, 0, 0);
    tick();
    stream(80, 24'h0C0000, reqs, fds);
    chk("t3_frame_done", 64'(fds), 64'd2);
    chk("t3_frames_done", 64'(bus.frames_done), 64'd4);

    // Two sync-loss episodes
    cnt = 0;
    for (int k = 0; k < 2; k++) begin
      bus.vram_synced = 1'b0;
      for (int i = 0; i < 50; i++) begin #1; cnt += int'(bus.vga_wait_vblank); tick(); end
      bus.vram_synced = 1'b1;
      for (int i = 0; i < 20; i++) begin #1; cnt += int'(bus.vga_wait_vblank); tick(); end
    end
    chk("t5_wait_pulses", 64'(cnt), 64'd2);
    chk("t5_sync_err", 64'(bus.sync_err), 64'd2);

    // BLANK waits for vblank, then drops vram_active
    send(2'd3, 0, 0, 0);
    chk("blank_px_ready", 64'(bus.px_ready), 64'd0);
    chk("blank_active_held", 64'(bus.vram_active), 64'd1);
    bus.vblank = 1'b1; tick(); tick();
    chk("blank_active_off", 64'(bus.vram_active), 64'd0);
    bus.vblank = 1'b0; tick();

    // Async reset while waiting for vblank
    send(2'd1, 16, 16, 0);
    bus.px_valid = 1'b1;
    reset = 1'b1;
    #1;
    chk("t6_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("t6_px_ready", 64'(bus.px_ready), 64'd0);
    chk("t6_H", 64'(bus.H), 64'd0);
    chk("t6_frames_done", 64'(bus.frames_done), 64'd0);
    chk("t6_sync_err", 64'(bus.sync_err), 64'd0);
    tick();
    reset = 1'b0; bus.px_valid = 1'b0;
    bus.vblank = 1'b1; tick(); tick();
    chk("t6_H_after", 64'(bus.H), 64'd0);
    chk("t6_ready_after", 64'(bus.cmd_ready), 64'd1);
    bus.vblank = 1'b0; tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/vga_sched.md
Name: vga_sched

Overview:
- Sequencer that sits between the streaming front end (HPS/DDR blitter) and the vga timing/VRAM block.
- Accepts commands to set a modeline, start VRAM blitting or blank output.
- Applies modeline changes only at vblank, and generates the vga/vram reset and control strobes.
- Forwards a valid/ready pixel stream into the vga VRAM write port, with per-frame pixel accounting and sync-loss recovery.

Parameters:
- PX_W, 24, pixel counter / frame size width
- FRM_W, 32, width of frames_done counter

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command strobe
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
- cmd_op  in  2  0=NOP, 1=SET_MODE, 2=BLIT_START, 3=BLANK
- m_H, m_V  in  16 each  requested visible width/height
- m_HFP, m_HS, m_HBP, m_VFP, m_VS, m_VBP, m_interlaced  in  8 each  requested timing
- H, V  out  16 each  applied modeline to vga
- HFP, HS, HBP, VFP, VS, VBP, interlaced  out  8 each  applied modeline to vga
- vga_reset, vga_frame_reset, vga_soft_reset, vga_wait_vblank, vram_reset  out  1 each  one-cycle control pulses
- vram_active  out  1  select VRAM output
- vblank  in  1  from vga
- vram_ready  in  1  from vga
- vram_synced  in  1  from vga
- px_valid  in  1  pixel valid
- px_ready  out  1  pixel accept
- px_rgb  in  24  {r,g,b}
- vram_req  out  1  write request to vga
- r_vram_in, g_vram_in, b_vram_in  out  8 each  write data
- frame_done  out  1  one-cycle pulse at last pixel of frame
- frames_done  out  FRM_W  completed streamed frames
- sync_err  out  16  sync-loss event count (saturating)

Behaviour:
- Reset values:
  - All pulses, vram_active, px_ready, vram_req, frame_done: 0.
  - cmd_ready: 1.
  - Counters: 0.
  - Modeline outputs: 0. With this value vga emits blank output, which is intended.
  - State IDLE.
- States and transitions:
  - IDLE: cmd_ready=1.
    - SET_MODE → latch m_* into shadow, go MODE_WAIT.
    - BLIT_START → VRAM_CLR.
    - BLANK → IDLE, vram_active stays 0.
  - MODE_WAIT: cmd_ready=0; wait for a vblank rising edge (vblank registered once, edge = vblank && !vblank_q).
  - MODE_APPLY: one cycle.
    - Copy shadow to modeline outputs.
    - Pulse vga_reset and vram_reset.
    - Clear vram_active.
    - Go IDLE.
  - VRAM_CLR: one cycle.
    - Pulse vram_reset and vga_frame_reset.
    - Clear pixel counter.
    - Set vram_active=1.
    - Go STREAM.
  - STREAM: cmd_ready=1.
    - SET_MODE → px_ready drops the same cycle, latch shadow, go MODE_WAIT.
    - BLANK → wait for vblank edge, then clear vram_active, go IDLE.
    - BLIT_START → re-enter VRAM_CLR.
    - NOP ignored everywhere.
- Pixel path (STREAM only):
  - px_ready = vram_ready && no BLANK pending.
  - vram_req = px_valid && px_ready (combinational, full rate).
  - On accept: rgb_q ← px_rgb. r/g/b_vram_in = rgb_q, held until the next accept. This is required because the vga write strobe lags vram_req by one cycle.
- Frame size:
  - frame_size = (H*V) >> (interlaced!=0), computed from the applied modeline, PX_W bits, registered in MODE_APPLY.
  - On each accept: px_cnt+1. When px_cnt+1 == frame_size: px_cnt ← 0, frame_done pulses the same cycle as the last vram_req, and frames_done increments (wraps).
  - frame_size==0 → px_ready forced 0.
- Sync loss:
  - In STREAM, a falling edge of vram_synced → one-cycle vga_wait_vblank pulse and sync_err+1 (saturates at FFFF).
  - Pulse is not repeated while vram_synced stays low.
- Simultaneous events:
  - Command accepted on the same cycle as a pixel accept: the pixel is written.
  - vblank edge on the same cycle as SET_MODE acceptance: not used; the next edge is required.
- Async reset mid-operation returns everything to reset values immediately. Outputs never glitch to stale modeline data.

Test Plan:
1. Reset, SET_MODE H=320,V=240,interlaced=0 at vblank=0 → H stays 0 until vblank rises; 1 cycle after the edge, H=320/V=240 with vga_reset=1 and vram_reset=1 for exactly one cycle; cmd_ready back to 1.
2. After test 1, BLIT_START then 76800 px_valid beats with vram_ready=1 → vram_reset and vga_frame_reset 1 cycle, vram_active=1, 76800 vram_req pulses, frame_done on the 76800th, frames_done=1, px_cnt=0.
3. Interlaced=1, H=640, V=480 → frame_done every 153600 accepts.
4. vram_ready toggled 0 for 10 cycles mid-frame → px_ready=0, no vram_req; r/g/b_vram_in holds the last pixel; count continues correctly afterwards.
5. In STREAM, drop vram_synced for 50 cycles twice → exactly two vga_wait_vblank pulses, sync_err=2.
6. Assert reset during MODE_WAIT with px_valid=1 → all outputs at reset values the same cycle; after release, state IDLE and modeline 0.
